alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, ring duration in tick_1s pulses (1..511).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze duration in tick_1s pulses (1..511).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..15).
REQ-004 clk  input  1  clock; reset reset_, asynchronous, active-low; clock clk.
REQ-005 reset_  input  1  asynchronous active-low reset.
REQ-006 tick_1s  input  1  one-cycle pulse, once per second, synchronous to clk.
REQ-007 en  input  1  alarm armed (level).
REQ-008 t_d0..t_d3  input  4 each  current time BCD: minute units, minute tens, hour units, hour tens.
REQ-009 a_d0..a_d3  input  4 each  stored alarm BCD from alarm register, same digit order.
REQ-010 btn_stop  input  1  debounced level; rising edge = stop request.
REQ-011 btn_snooze  input  1  debounced level; rising edge = snooze request.
REQ-012 ringing  output  1  high in RINGING state.
REQ-013 snoozing  output  1  high in SNOOZE state.
REQ-014 buzz  output  1  buzzer drive, beep pattern.
REQ-015 snooze_left  output  4  remaining snoozes for current event.

Function
REQ-016 match SHALL be 1 when all four t_d digits equal corresponding a_d digits; registered match_d SHALL hold previous-cycle match.
REQ-017 FSM SHALL have states IDLE, RINGING, SNOOZE.
REQ-018 IDLE->RINGING on cycle where en=1 and match=1 and match_d=0 (rising edge only); holding match after stop SHALL NOT retrigger.
REQ-019 On IDLE->RINGING: ring counter loads RING_SEC, snooze_left loads MAX_SNOOZE, buzz phase set to 1.
REQ-020 RINGING: ring counter decrements on tick_1s; tick_1s with counter==1 -> IDLE.
REQ-021 RINGING: btn_stop rising edge -> IDLE next cycle.
REQ-022 RINGING: btn_snooze rising edge with snooze_left>0 -> SNOOZE, snooze counter loads SNOOZE_SEC, snooze_left decrements by 1; with snooze_left==0 request SHALL be ignored.
REQ-023 SNOOZE: snooze counter decrements on tick_1s; tick_1s with counter==1 -> RINGING, ring counter reloads RING_SEC, buzz phase 1, snooze_left unchanged.
REQ-024 SNOOZE: btn_stop rising edge -> IDLE; btn_snooze ignored.
REQ-025 Stop and snooze edges in the same cycle: stop wins.
REQ-026 en=0 in any state -> IDLE next cycle, counters frozen, outputs low.
REQ-027 Button edge and tick_1s in same cycle: button action wins; tick not applied to the reloaded counter.
REQ-028 buzz = ringing AND phase; phase toggles on each tick_1s in RINGING.
REQ-029 All outputs registered or decoded directly from registered state; latency from trigger/button edge to output change: 1 cycle.
REQ-030 Counters 9 bits wide; no wrap below 1 (transition precedes underflow).
REQ-031 Edge detectors for btn_stop/btn_snooze SHALL reset to 0, so a button held through reset deassertion is not an edge.

Reset
REQ-032 reset_=0 SHALL force IDLE, ringing=0, snoozing=0, buzz=0, snooze_left=0, counters=0, match_d=0, phase=0, edge registers=0.
REQ-033 Reset mid-RINGING or mid-SNOOZE SHALL abort the event; after release, a new ring requires a fresh match rising edge.

Structure
REQ-034 Shared package alarm_pkg SHALL hold state encoding (IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2) and default parameter constants.
REQ-035 One sub-module rise_det (1-bit registered rising-edge detector, clk/reset_) SHALL be instantiated for each button.

Verification (RING_SEC=4, SNOOZE_SEC=6, MAX_SNOOZE=2)
REQ-036 en=1, alarm 07:30, time steps 07:29->07:30 -> ringing=1 one cycle later, buzz=1, snooze_left=2; after 4 ticks ringing=0.
REQ-037 Ringing, btn_stop edge -> IDLE next cycle; time held 07:30 for 10 ticks -> no re-ring.
REQ-038 Ringing, snooze edge x3 separated by 6-tick snoozes -> snooze_left 1, then 0, third snooze ignored, ring continues until timeout.
REQ-039 Stop and snooze edges same cycle while ringing -> IDLE, snooze_left unchanged.
REQ-040 en dropped mid-SNOOZE -> IDLE next cycle, all outputs 0; reset_ pulsed mid-RINGING -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller slice.
// Holds the FSM state encoding, counter widths and the default timing
// constants used as parameter defaults by alarm_ctrl.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam int CNT_W          = 9;    // ring / snooze second counters
  localparam int SNZ_W          = 4;    // remaining-snooze counter
  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector for a debounced button level.
// Ports:
//   clk, reset_ : clock, asynchronous active-low reset
//   din         : debounced input level
//   rise        : high for the cycle in which din goes 0 -> 1
// valid_r blocks the first cycle after reset, so a button already held
// when reset is released is never reported as a new press.
module rise_det
  import alarm_pkg::*;
(
  input  logic clk,
  input  logic reset_,
  input  logic din,
  output logic rise
);

  logic prev_r;
  logic valid_r;

  // History of the input level plus a flag marking that history as valid.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      prev_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      prev_r  <= din;
      valid_r <= 1'b1;
    end
  end

  assign rise = din & ~prev_r & valid_r;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: compares current time against the stored alarm,
// rings for RING_SEC seconds, supports up to MAX_SNOOZE snoozes of
// SNOOZE_SEC seconds each, and can be stopped at any time.
// Ports:
//   clk, reset_       : clock, asynchronous active-low reset
//   tick_1s           : one-cycle pulse per second
//   en                : alarm armed (level); low forces IDLE
//   t_d0..t_d3        : current time BCD (min units, min tens, hr units, hr tens)
//   a_d0..a_d3        : alarm time BCD, same order
//   btn_stop          : stop button level (rising edge acts)
//   btn_snooze        : snooze button level (rising edge acts)
//   ringing, snoozing : state indicators
//   buzz              : beep pattern, toggles every second while ringing
//   snooze_left       : snoozes still available for the current event
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             tick_1s,
  input  logic             en,
  input  logic [3:0]       t_d0,
  input  logic [3:0]       t_d1,
  input  logic [3:0]       t_d2,
  input  logic [3:0]       t_d3,
  input  logic [3:0]       a_d0,
  input  logic [3:0]       a_d1,
  input  logic [3:0]       a_d2,
  input  logic [3:0]       a_d3,
  input  logic             btn_stop,
  input  logic             btn_snooze,
  output logic             ringing,
  output logic             snoozing,
  output logic             buzz,
  output logic [SNZ_W-1:0] snooze_left
);

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [SNZ_W-1:0] SNZ_LOAD    = SNZ_W'(MAX_SNOOZE);

  state_t           state_r;
  logic [CNT_W-1:0] ring_cnt_r;
  logic [CNT_W-1:0] snz_cnt_r;
  logic [SNZ_W-1:0] left_r;
  logic             phase_r;
  logic             match_d_r;
  logic             live_r;
  logic             match_s;
  logic             trig_s;
  logic             stop_s;
  logic             snz_s;

  rise_det u_stop_det (
    .clk    (clk),
    .reset_ (reset_),
    .din    (btn_stop),
    .rise   (stop_s)
  );

  rise_det u_snooze_det (
    .clk    (clk),
    .reset_ (reset_),
    .din    (btn_snooze),
    .rise   (snz_s)
  );

  assign match_s = (t_d0 == a_d0) && (t_d1 == a_d1) &&
                   (t_d2 == a_d2) && (t_d3 == a_d3);

  // live_r keeps a time that already matches at reset release from
  // counting as a fresh match edge.
  assign trig_s = en && match_s && !match_d_r && live_r;

  // Main alarm FSM with its counters; button edges take priority over ticks.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r    <= IDLE;
      ring_cnt_r <= {CNT_W{1'b0}};
      snz_cnt_r  <= {CNT_W{1'b0}};
      left_r     <= {SNZ_W{1'b0}};
      phase_r    <= 1'b0;
      match_d_r  <= 1'b0;
      live_r     <= 1'b0;
    end else begin
      match_d_r <= match_s;
      live_r    <= 1'b1;
      if (!en) begin
        // Disarming aborts the event; counters hold their values.
        state_r <= IDLE;
        left_r  <= {SNZ_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            if (trig_s) begin
              state_r    <= RINGING;
              ring_cnt_r <= RING_LOAD;
              left_r     <= SNZ_LOAD;
              phase_r    <= 1'b1;
            end
          end
          RINGING: begin
            if (stop_s) begin
              state_r <= IDLE;
            end else if (snz_s && (left_r != {SNZ_W{1'b0}})) begin
              state_r   <= SNOOZE;
              snz_cnt_r <= SNOOZE_LOAD;
              left_r    <= left_r - {{(SNZ_W-1){1'b0}}, 1'b1};
            end else if (tick_1s) begin
              phase_r <= ~phase_r;
              // Leave on the last second rather than counting through zero.
              if (ring_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                state_r <= IDLE;
              end else begin
                ring_cnt_r <= ring_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          SNOOZE: begin
            if (stop_s) begin
              state_r <= IDLE;
            end else if (tick_1s) begin
              if (snz_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                state_r    <= RINGING;
                ring_cnt_r <= RING_LOAD;
                phase_r    <= 1'b1;
              end else begin
                snz_cnt_r <= snz_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign ringing     = (state_r == RINGING);
  assign snoozing    = (state_r == SNOOZE);
  assign buzz        = ringing & phase_r;
  assign snooze_left = left_r;

endmodule
